// File: rtl/pixel_frame_buffer.sv
// Pixel frame buffer: rescales unsigned 8-bit pixels to 0..+127 and packs a full frame
// for the first neuron layer, holding it until the layer controller acknowledges it.
module pixel_frame_buffer #(
    parameter  int NUM_PIXELS = 784,
    parameter  int RESOLUTION = 8,
    localparam int CNT_W      = $clog2(NUM_PIXELS) + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      pixel_in,
    input  logic                            pixel_valid,
    input  logic                            frame_start,
    output logic                            pixel_ready,
    output logic [RESOLUTION*NUM_PIXELS-1:0] input_data,
    output logic                            frame_valid,
    input  logic                            frame_ack,
    output logic [CNT_W-1:0]                pixel_count,
    output logic                            frame_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

    state_t                        state, state_nxt;
    logic                          accept;
    logic                          wr_en;
    logic [CNT_W-1:0]              wr_idx;
    logic [CNT_W-1:0]              count_nxt;
    logic                          err_nxt;
    logic signed [RESOLUTION-1:0]  elem;

    // Logical shift right keeps the sign bit clear, so the result is always non-negative.
    function automatic logic signed [RESOLUTION-1:0] rescale(input logic [7:0] p);
        rescale = RESOLUTION'({1'b0, p[7:1]});
    endfunction

    assign pixel_ready = (state != FULL);
    assign accept      = pixel_valid && pixel_ready;
    assign elem        = rescale(pixel_in);

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_idx    = pixel_count;
        count_nxt = pixel_count;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    wr_en     = 1'b1;
                    wr_idx    = '0;
                    count_nxt = CNT_W'(1);
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (frame_start) begin
                        // Restart: older elements stay and are overwritten by the new frame.
                        wr_idx    = '0;
                        count_nxt = CNT_W'(1);
                        err_nxt   = 1'b1;
                    end else begin
                        wr_idx    = pixel_count;
                        count_nxt = pixel_count + CNT_W'(1);
                        if (pixel_count == LAST_IDX) begin
                            state_nxt = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (frame_ack) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pixel_count <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            pixel_count <= count_nxt;
            frame_valid <= (state_nxt == FULL);
            frame_err   <= err_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            input_data <= '0;
        end else begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                if (wr_en && (wr_idx == CNT_W'(i))) begin
                    input_data[(i+1)*RESOLUTION-1 -: RESOLUTION] <= elem;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Directed self-checking bench for pixel_frame_buffer with a 4-pixel frame.
module tb_pixel_frame_buffer;

    localparam int NP    = 4;
    localparam int RES   = 8;
    localparam int CNT_W = $clog2(NP) + 1;

    logic                clk;
    logic                reset;
    logic [7:0]          pixel_in;
    logic                pixel_valid;
    logic                frame_start;
    logic                pixel_ready;
    logic [RES*NP-1:0]   input_data;
    logic                frame_valid;
    logic                frame_ack;
    logic [CNT_W-1:0]    pixel_count;
    logic                frame_err;

    int n_checks;
    int n_fail;

    pixel_frame_buffer #(.NUM_PIXELS(NP), .RESOLUTION(RES)) dut (
        .clk(clk),
        .reset(reset),
        .pixel_in(pixel_in),
        .pixel_valid(pixel_valid),
        .frame_start(frame_start),
        .pixel_ready(pixel_ready),
        .input_data(input_data),
        .frame_valid(frame_valid),
        .frame_ack(frame_ack),
        .pixel_count(pixel_count),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p, input logic fs);
        pixel_in    = p;
        pixel_valid = 1'b1;
        frame_start = fs;
        step();
        pixel_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pixel_in = 8'h00; pixel_valid = 1'b0; frame_start = 1'b0; frame_ack = 1'b0;
        step();
        step();
        n_checks++;
        if (input_data !== 32'h0 || pixel_count !== 3'd0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: data=%h cnt=%0d fv=%b err=%b, want 0/0/0/0",
                     input_data, pixel_count, frame_valid, frame_err);
        end
        reset = 1'b1;
        step();
        n_checks++;
        if (pixel_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", pixel_ready);
        end
    endtask

    task automatic test_fill();
        pixel_valid = 1'b1;
        pixel_in = 8'hFF; step();
        pixel_in = 8'h80; step();
        pixel_in = 8'h02; step();
        n_checks++;
        if (pixel_count !== 3'd3 || frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_partial: cnt=%0d fv=%b, want 3/0", pixel_count, frame_valid);
        end
        pixel_in = 8'h01; step();
        pixel_valid = 1'b0;
        n_checks++;
        if (frame_valid !== 1'b1 || input_data !== 32'h0001407F || pixel_ready !== 1'b0 || pixel_count !== 3'd4) begin
            n_fail++;
            $display("FAIL fill_full: fv=%b data=%h rdy=%b cnt=%0d, want 1/0001407f/0/4",
                     frame_valid, input_data, pixel_ready, pixel_count);
        end
    endtask

    task automatic test_hold_full();
        pixel_valid = 1'b1;
        pixel_in    = 8'h55;
        frame_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (input_data !== 32'h0001407F || pixel_count !== 3'd4 || frame_valid !== 1'b1 || frame_err !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_full[%0d]: data=%h cnt=%0d fv=%b err=%b, want 0001407f/4/1/0",
                         i, input_data, pixel_count, frame_valid, frame_err);
            end
        end
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        frame_ack   = 1'b1;
        step();
        frame_ack   = 1'b0;
        n_checks++;
        if (frame_valid !== 1'b0 || pixel_count !== 3'd0 || pixel_ready !== 1'b1 || input_data !== 32'h0001407F) begin
            n_fail++;
            $display("FAIL ack_release: fv=%b cnt=%0d rdy=%b data=%h, want 0/0/1/0001407f",
                     frame_valid, pixel_count, pixel_ready, input_data);
        end
    endtask

    task automatic test_restart();
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        send(8'h10, 1'b1);
        n_checks++;
        if (frame_err !== 1'b1 || pixel_count !== 3'd1 || input_data !== 32'h00011808 || frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL restart: err=%b cnt=%0d data=%h fv=%b, want 1/1/00011808/0",
                     frame_err, pixel_count, input_data, frame_valid);
        end
        step();
        n_checks++;
        if (frame_err !== 1'b0 || pixel_count !== 3'd1) begin
            n_fail++;
            $display("FAIL restart_pulse: err=%b cnt=%0d, want 0/1", frame_err, pixel_count);
        end
        send(8'h40, 1'b0);
        send(8'h60, 1'b0);
        send(8'h80, 1'b0);
        n_checks++;
        if (frame_valid !== 1'b1 || input_data !== 32'h40302008 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_frame: fv=%b data=%h err=%b, want 1/40302008/0",
                     frame_valid, input_data, frame_err);
        end
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
    endtask

    task automatic test_async_reset();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        n_checks++;
        if (pixel_count !== 3'd3) begin
            n_fail++;
            $display("FAIL areset_pre: cnt=%0d want 3", pixel_count);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (input_data !== 32'h0 || pixel_count !== 3'd0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_clear: data=%h cnt=%0d fv=%b err=%b, want 0/0/0/0",
                     input_data, pixel_count, frame_valid, frame_err);
        end
        step();
        reset = 1'b1;
        send(8'h02, 1'b0);
        send(8'h04, 1'b0);
        send(8'h06, 1'b0);
        send(8'h08, 1'b0);
        n_checks++;
        if (frame_valid !== 1'b1 || input_data !== 32'h04030201 || pixel_count !== 3'd4) begin
            n_fail++;
            $display("FAIL areset_frame: fv=%b data=%h cnt=%0d, want 1/04030201/4",
                     frame_valid, input_data, pixel_count);
        end
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
    endtask

    task automatic test_gaps();
        logic [7:0] pix [4];
        int         gaps [4];
        pix[0] = 8'h9A; pix[1] = 8'h33; pix[2] = 8'hFE; pix[3] = 8'h07;
        gaps[0] = 2; gaps[1] = 1; gaps[2] = 3; gaps[3] = 1;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                pixel_in  = 8'hEE;
                frame_ack = g[0] ? 1'b0 : 1'b1;
                step();
                frame_ack = 1'b0;
                n_checks++;
                if (pixel_count !== CNT_W'(k) || frame_valid !== 1'b0 || pixel_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gap_hold[%0d.%0d]: cnt=%0d fv=%b rdy=%b, want %0d/0/1",
                             k, g, pixel_count, frame_valid, pixel_ready, k);
                end
            end
            send(pix[k], 1'b0);
        end
        n_checks++;
        if (frame_valid !== 1'b1 || input_data !== 32'h037F194D) begin
            n_fail++;
            $display("FAIL gap_frame: fv=%b data=%h, want 1/037f194d", frame_valid, input_data);
        end
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        send(8'h40, 1'b0);
        n_checks++;
        if (frame_valid !== 1'b1 || input_data !== 32'h20181008) begin
            n_fail++;
            $display("FAIL b2b_frame: fv=%b data=%h, want 1/20181008", frame_valid, input_data);
        end
        frame_ack   = 1'b1;
        pixel_valid = 1'b1;
        pixel_in    = 8'hAA;
        step();
        frame_ack   = 1'b0;
        n_checks++;
        if (frame_valid !== 1'b0 || pixel_count !== 3'd0 || input_data !== 32'h20181008) begin
            n_fail++;
            $display("FAIL b2b_ack: fv=%b cnt=%0d data=%h, want 0/0/20181008",
                     frame_valid, pixel_count, input_data);
        end
        pixel_in = 8'h7E;
        step();
        pixel_valid = 1'b0;
        n_checks++;
        if (pixel_count !== 3'd1 || input_data !== 32'h2018103F || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_next: cnt=%0d data=%h err=%b, want 1/2018103f/0",
                     pixel_count, input_data, frame_err);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fill();
        test_hold_full();
        test_restart();
        test_async_reset();
        test_gaps();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
